pipelined_handshake_multiplier: RTL and testbench

//  Iterative fixed-point multiplier; successor to the single-rate multi-cycle multiplier.

---
 rtl/pipelined_handshake_multiplier.sv | 199 +++++++++++++++++++
 tb/tb_pipelined_handshake_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_handshake_multiplier.sv
// pipelined_handshake_multiplier
//   Iterative fixed-point multiplier with valid/ready handshakes on both sides.
//   Each CALC cycle it consumes BITS_PER_CYCLE multiplier bits. Operands can be
//   signed (two's complement) or unsigned. Overflow of the formatted result is
//   reported alongside it.
//
//   Handshake: a transfer happens on a rising edge where valid and ready are both
//   high. in_ready is combinational, so a consumer that accepts a result can
//   present new operands on the same edge. y/overflow are only meaningful while
//   out_valid is high, and they are held stable until out_ready is seen.
//
//   Optional feature: define MUL_SAT_EN to clamp y to the largest or smallest
//   representable value when overflow is set. Without it, y is the wrapped slice.
//
//   Constraints: C_WIDTH must be a multiple of BITS_PER_CYCLE (1, 2 or 4).
//   FIXED_POINT must be in 0..C_WIDTH-1.

module pipelined_handshake_multiplier #(
   parameter int C_WIDTH        = 32,
   parameter int FIXED_POINT    = 8,
   parameter int BITS_PER_CYCLE = 1,
   parameter int SIGNED         = 1
) (
   input  logic               ctl_clk,
   input  logic               reset,
   input  logic [C_WIDTH-1:0] a,
   input  logic [C_WIDTH-1:0] b,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [C_WIDTH-1:0] y,
   output logic               overflow,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy
);

   localparam int W     = C_WIDTH;
   localparam int FP    = FIXED_POINT;
   localparam int BPC   = BITS_PER_CYCLE;
   localparam int N     = W / BPC;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int HI_W  = W + BPC;

   localparam logic [W-1:0]     ONE_W    = 1;
   localparam logic [2*W-1:0]   ONE_2W   = 1;
   localparam logic [CNT_W-1:0] ONE_CNT  = 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   logic [W-1:0]     a_mag;      // |a| captured at accept
   logic             sign;       // result sign captured at accept
   logic [2*W-1:0]   acc;        // partial product (high) and remaining multiplier bits (low)
   logic [CNT_W-1:0] cnt;        // CALC iteration index

   // accept-side signals
   logic           accept;
   logic           a_neg;
   logic           b_neg;
   logic [W-1:0]   a_mag_in;
   logic [W-1:0]   b_mag_in;

   // iteration datapath
   logic [BPC-1:0]   slice;
   logic [HI_W-1:0]  partial;
   logic [HI_W-1:0]  sum;
   logic [2*W-1:0]   acc_next;

   // finishing datapath
   logic [2*W-1:0]   prod_fix;
   logic [W-1:0]     y_wrap;
   logic [W-1:0]     y_fmt;
   logic             ovf_calc;

   // Handshake and status outputs depend only on the current state and out_ready.
   always_comb begin
      in_ready = (state == IDLE) || ((state == DONE) && out_ready);
      busy     = (state != IDLE);
      accept   = in_valid && in_ready;
   end

   // Operand magnitudes and result sign. |-2^(W-1)| fits exactly in W unsigned bits.
   always_comb begin
      a_neg    = (SIGNED != 0) && a[W-1];
      b_neg    = (SIGNED != 0) && b[W-1];
      a_mag_in = a_neg ? (~a + ONE_W) : a;
      b_mag_in = b_neg ? (~b + ONE_W) : b;
   end

   // One radix-2^BPC step. Add |a| times the lowest multiplier slice into the high half.
   // Then shift the whole accumulator right by BPC, so the consumed slice falls off.
   always_comb begin
      slice    = acc[BPC-1:0];
      partial  = HI_W'(a_mag) * HI_W'(slice);
      sum      = HI_W'(acc[2*W-1:W]) + partial;
      acc_next = {sum, acc[W-1:BPC]};
   end

   // Apply the sign to the unsigned product and take the fixed-point window.
   always_comb begin
      prod_fix = sign ? (~acc + ONE_2W) : acc;
      y_wrap   = prod_fix[W-1+FP:FP];
   end

   // Overflow means the bits above the result window are not a pure extension of it.
   generate
      if (SIGNED != 0) begin : g_ovf_signed
         assign ovf_calc = (prod_fix[2*W-1:W-1+FP] != {(W+1-FP){prod_fix[2*W-1]}});
      end else begin : g_ovf_unsigned
         assign ovf_calc = (prod_fix[2*W-1:W+FP] != '0);
      end
   endgenerate

   // Fraction bits below the window are truncated on purpose.
   generate
      if (FP > 0) begin : g_frac
         logic unused_frac;
         assign unused_frac = ^prod_fix[(FP > 0 ? FP-1 : 0):0];
      end
   endgenerate

   // Result formatting: wrapped slice, or a clamped value when saturation is built in.
   always_comb begin
      y_fmt = y_wrap;
`ifdef MUL_SAT_EN
      if (ovf_calc) begin
         if (SIGNED != 0) begin
            y_fmt = sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         end else begin
            y_fmt = {W{1'b1}};
         end
      end
`endif
   end

   // Control FSM with registered result outputs. Reset discards any operation in flight.
   always_ff @(posedge ctl_clk) begin
      if (reset) begin
         state     <= IDLE;
         a_mag     <= '0;
         sign      <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         y         <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_mag <= a_mag_in;
                  sign  <= a_neg ^ b_neg;
                  acc   <= {{W{1'b0}}, b_mag_in};
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               acc <= acc_next;
               cnt <= cnt + ONE_CNT;
               if (cnt == LAST_CNT) begin
                  state <= FIX;
               end
            end
            FIX: begin
               y         <= y_fmt;
               overflow  <= ovf_calc;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               // y/overflow stay untouched here, so the held result stays stable under backpressure.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     a_mag <= a_mag_in;
                     sign  <= a_neg ^ b_neg;
                     acc   <= {{W{1'b0}}, b_mag_in};
                     cnt   <= '0;
                     state <= CALC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipelined_handshake_multiplier.sv
// Testbench for pipelined_handshake_multiplier.
//   dut_s: C_WIDTH=16, FIXED_POINT=8, BITS_PER_CYCLE=1, SIGNED=1
//   dut_u: C_WIDTH=16, FIXED_POINT=8, BITS_PER_CYCLE=4, SIGNED=0
// Expected results with MUL_SAT_EN defined follow the clamping rule.

module tb_pipelined_handshake_multiplier;

   localparam int W = 16;
`ifdef MUL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic ctl_clk = 1'b0;
   always #5 ctl_clk = ~ctl_clk;
   logic reset;

   logic [W-1:0] s_a, s_b, s_y;
   logic         s_iv, s_ir, s_ovf, s_ov, s_or, s_busy;
   logic [W-1:0] u_a, u_b, u_y;
   logic         u_iv, u_ir, u_ovf, u_ov, u_or, u_busy;

   pipelined_handshake_multiplier #(
      .C_WIDTH(W), .FIXED_POINT(8), .BITS_PER_CYCLE(1), .SIGNED(1)
   ) dut_s (
      .ctl_clk(ctl_clk), .reset(reset), .a(s_a), .b(s_b), .in_valid(s_iv),
      .in_ready(s_ir), .y(s_y), .overflow(s_ovf), .out_valid(s_ov),
      .out_ready(s_or), .busy(s_busy)
   );

   pipelined_handshake_multiplier #(
      .C_WIDTH(W), .FIXED_POINT(8), .BITS_PER_CYCLE(4), .SIGNED(0)
   ) dut_u (
      .ctl_clk(ctl_clk), .reset(reset), .a(u_a), .b(u_b), .in_valid(u_iv),
      .in_ready(u_ir), .y(u_y), .overflow(u_ovf), .out_valid(u_ov),
      .out_ready(u_or), .busy(u_busy)
   );

   // ---------------- scoreboard ----------------
   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge ctl_clk);
      #1;
   endtask

   // Wait for out_valid on the selected DUT; lat counts edges after the previous tick.
   task automatic wait_valid(input bit sel, output int lat);
      lat = 0;
      while (((sel ? u_ov : s_ov) !== 1'b1) && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   // One complete operation with out_ready held high; result consumed afterwards.
   task automatic run_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_y, input logic exp_ovf,
                         input int exp_lat, input string name);
      int lat;
      if (sel) begin u_a = a; u_b = b; u_iv = 1'b1; u_or = 1'b1; end
      else     begin s_a = a; s_b = b; s_iv = 1'b1; s_or = 1'b1; end
      exp_q.push_back(exp_y);
      check({name, " in_ready"}, 32'(sel ? u_ir : s_ir), 32'd1);
      tick();
      if (sel) begin u_iv = 1'b0; u_a = '0; u_b = '0; end
      else     begin s_iv = 1'b0; s_a = '0; s_b = '0; end
      wait_valid(sel, lat);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " y"}, 32'(sel ? u_y : s_y), 32'(exp_q.pop_front()));
      check({name, " ovf"}, 32'(sel ? u_ovf : s_ovf), 32'(exp_ovf));
      tick();
      check({name, " consumed"}, 32'(sel ? u_ov : s_ov), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y_wrap;
      logic [W-1:0] y_sat;
      logic         ovf;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int lat;
      int stale;
      // a, b, y (wrapped), y (saturated), overflow
      vecs[0] = '{16'h0180, 16'h0200, 16'h0300, 16'h0300, 1'b0}; //  1.5 * 2.0
      vecs[1] = '{16'hFF00, 16'h0280, 16'hFD80, 16'hFD80, 1'b0}; // -1.0 * 2.5
      vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 1'b1}; // -128 * -128
      vecs[3] = '{16'h7F00, 16'h0200, 16'hFE00, 16'h7FFF, 1'b1}; //  127 * 2
      vecs[4] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0}; // zero operand
      vecs[5] = '{16'hFFFF, 16'h0080, 16'hFFFF, 16'hFFFF, 1'b0}; // -1/256 * 0.5 floors to -1/256
      vecs[6] = '{16'h0001, 16'h0080, 16'h0000, 16'h0000, 1'b0}; //  1/256 * 0.5 truncates to 0
      vecs[7] = '{16'h8000, 16'h0200, 16'h0000, 16'h8000, 1'b1}; // -128 * 2 (negative overflow)
      vecs[8] = '{16'hFF00, 16'hFF00, 16'h0100, 16'h0100, 1'b0}; // -1 * -1
      vecs[9] = '{16'h8000, 16'h0100, 16'h8000, 16'h8000, 1'b0}; // -128 * 1 (exact minimum)

      s_a = '0; s_b = '0; s_iv = 1'b0; s_or = 1'b1;
      u_a = '0; u_b = '0; u_iv = 1'b0; u_or = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      check("reset y", 32'(s_y), 32'h0);
      check("reset ovf", 32'(s_ovf), 32'h0);
      check("reset out_valid", 32'(s_ov), 32'h0);
      check("reset busy", 32'(s_busy), 32'h0);
      check("reset in_ready", 32'(s_ir), 32'h1);
      check("reset u in_ready", 32'(u_ir), 32'h1);

      // table-driven signed vectors
      for (int i = 0; i < 10; i++) begin
         run_op(1'b0, vecs[i].a, vecs[i].b, SAT ? vecs[i].y_sat : vecs[i].y_wrap,
                vecs[i].ovf, 17, $sformatf("vec%0d", i));
      end

      // unsigned radix-16 instance
      run_op(1'b1, 16'hFFFF, 16'h0100, 16'hFFFF, 1'b0, 5, "u_max");
      run_op(1'b1, 16'hFFFF, 16'h0200, SAT ? 16'hFFFF : 16'hFFFE, 1'b1, 5, "u_ovf");
      run_op(1'b1, 16'h0300, 16'h0280, 16'h0780, 1'b0, 5, "u_mid");

      // backpressure: hold the result, then accept new operands on the consume edge
      s_a = 16'h0180; s_b = 16'h0200; s_iv = 1'b1; s_or = 1'b0;
      tick();
      s_a = 16'hFF00; s_b = 16'h0280;   // next operands offered while the first result is stalled
      wait_valid(1'b0, lat);
      check("bp latency", 32'(lat), 32'd17);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp hold%0d valid", k), 32'(s_ov), 32'd1);
         check($sformatf("bp hold%0d y", k), 32'(s_y), 32'h0300);
         check($sformatf("bp hold%0d in_ready", k), 32'(s_ir), 32'd0);
         tick();
      end
      s_or = 1'b1;
      #1;
      check("bp in_ready on release", 32'(s_ir), 32'd1);
      tick();
      s_iv = 1'b0;
      check("bp valid drops", 32'(s_ov), 32'd0);
      check("bp busy", 32'(s_busy), 32'd1);
      wait_valid(1'b0, lat);
      check("bp second latency", 32'(lat), 32'd17);
      check("bp second y", 32'(s_y), 32'hFD80);
      check("bp second ovf", 32'(s_ovf), 32'd0);
      tick();

      // reset during the 4th CALC cycle
      s_a = 16'h0180; s_b = 16'h0200; s_iv = 1'b1;
      tick();
      s_iv = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst busy", 32'(s_busy), 32'd0);
      check("rst out_valid", 32'(s_ov), 32'd0);
      check("rst y", 32'(s_y), 32'h0);
      check("rst in_ready", 32'(s_ir), 32'd1);
      stale = 0;
      for (int k = 0; k < 25; k++) begin
         if (s_ov !== 1'b0) stale++;
         tick();
      end
      check("rst no stale result", 32'(stale), 32'd0);

      // the block still works after the abort
      run_op(1'b0, 16'h0280, 16'hFF00, 16'hFD80, 1'b0, 17, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
